// File: rtl/gray_dec_arbiter_if.sv
// Bus bundle for gray_dec_arbiter: NREQ gray-coded request channels in, one
// decoded result channel out, plus read-only debug taps of the arbiter state.
//
// Handshake semantics (all channels): a word transfers on a rising clk edge
// where valid && ready are both high. A source holds valid and its data stable
// until that edge; ready may depend combinationally on valid, never the
// reverse. The arbiter raises at most one req_ready bit per cycle.
interface gray_dec_arbiter_if #(
    parameter int SIZE = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_gray;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [SIZE-1:0]      out_bin;
    logic [IDW-1:0]       out_id;
    // Debug taps: output FSM state (1 = FULL) and round-robin pointer.
    logic                 dbg_state;
    logic [IDW-1:0]       dbg_ptr;

    // Requesters and consumer side.
    modport master (
        output req_valid, req_gray, out_ready,
        input  req_ready, out_valid, out_bin, out_id, dbg_state, dbg_ptr
    );

    // Arbiter/decoder side.
    modport slave (
        input  req_valid, req_gray, out_ready,
        output req_ready, out_valid, out_bin, out_id, dbg_state, dbg_ptr
    );
endinterface

// File: rtl/gray_dec_arbiter.sv
// gray_dec_arbiter: round-robin arbiter in front of one registered
// gray-to-binary decode stage. One result per cycle while out_ready stays high;
// each result carries the index of the requester that produced it.
// Optional feature macro: GRAY_DEC_ARB_CNT_EN adds a 16-bit wrapping count of
// completed output handshakes on port grant_cnt.
module gray_dec_arbiter #(
    parameter int SIZE = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic clk,
    input  logic rst,
    gray_dec_arbiter_if.slave bus
`ifdef GRAY_DEC_ARB_CNT_EN
    ,
    output logic [15:0] grant_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic            out_valid_q;
    logic [SIZE-1:0] out_bin_q;
    logic [IDW-1:0]  out_id_q;

    logic            accept;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic [SIZE-1:0] sel_gray;
    int              scan;

    // Binary bit k is the XOR of all gray bits from the MSB down to k.
    function automatic logic [SIZE-1:0] gray2bin(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b[SIZE-1] = g[SIZE-1];
        for (int k = SIZE - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // The output register can take a new word when empty or being drained now.
    assign accept = (state == EMPTY) || bus.out_ready;

    // Round-robin search from ptr upward with wrap; first valid requester wins.
    // Gated by rst so no handshake completes during the reset cycle.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        scan      = 0;
        if (accept && !rst) begin
            for (int off = 0; off < NREQ; off++) begin
                scan = int'(ptr) + off;
                if (scan >= NREQ) begin
                    scan = scan - NREQ;
                end
                if (!grant_any && bus.req_valid[scan]) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(scan);
                end
            end
            if (grant_any) begin
                grant_vec[grant_idx] = 1'b1;
            end
        end
    end

    // Pick the granted requester's gray word for the decoder.
    always_comb begin
        sel_gray = bus.req_gray[grant_idx*SIZE +: SIZE];
    end

    // Output FSM, result register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_id_q    <= '0;
            ptr         <= '0;
        end else if (accept) begin
            if (grant_any) begin
                state       <= FULL;
                out_valid_q <= 1'b1;
                out_bin_q   <= gray2bin(sel_gray);
                out_id_q    <= grant_idx;
                ptr         <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state       <= EMPTY;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_id    = out_id_q;
    assign bus.dbg_state = state;
    assign bus.dbg_ptr   = ptr;

`ifdef GRAY_DEC_ARB_CNT_EN
    // Count completed output handshakes; wraps freely at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end
`endif

endmodule
